// File: rtl/priority_arbiter.sv
// Request arbiter: fixed-priority (MODE=0) or round-robin (MODE=1) with a
// valid/ready grant handshake and fully registered outputs.
module priority_arbiter #(
  parameter int unsigned  NUM_REQ = 8,
  parameter int unsigned  MODE    = 0,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_inc;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     win_idx;
  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot;
  logic                 handshake;
  logic                 any_req;
  int unsigned          inc;
  int unsigned          off;
  int unsigned          sum;

  // Pointer successor: one past the current grant, wrapping at NUM_REQ.
  always_comb begin
    inc = 32'(grant_idx) + 32'd1;
    if (inc >= NUM_REQ) inc = 32'd0;
    ptr_inc = IDX_W'(inc);
  end

  // Search origin; a handshake edge already searches from the advanced pointer.
  always_comb begin
    handshake = (state == GRANT) && out_ready;
    any_req   = |req;
    start     = '0;
    if (MODE == 1) start = handshake ? ptr_inc : ptr;
  end

  // Winner: rotate requests so the origin sits at bit 0, take the lowest set bit.
  always_comb begin
    req2 = {req, req};
    rot  = NUM_REQ'(req2 >> start);
    off  = 32'd0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = 32'(j);
    end
    sum = 32'(start) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    win_idx = IDX_W'(sum);
  end

  // Grant FSM with registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= GRANT;
            out_valid    <= 1'b1;
            grant_idx    <= win_idx;
            grant_onehot <= NUM_REQ'(1) << win_idx;
          end
        end
        GRANT: begin
          if (out_ready) begin
            if (MODE == 1) ptr <= ptr_inc;
            if (any_req) begin
              grant_idx    <= win_idx;
              grant_onehot <= NUM_REQ'(1) << win_idx;
            end else begin
              state        <= IDLE;
              out_valid    <= 1'b0;
              grant_onehot <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: fixed-priority and round-robin instances with
// five requesters plus a single-requester instance, against a behavioural model.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic       out_ready;

  logic       v0, v1, v2;
  logic [2:0] gi0, gi1;
  logic [0:0] gi2;
  logic [4:0] oh0, oh1;
  logic [0:0] oh2;

  int errors = 0;
  int checks = 0;

  // Model state per instance: 0 = fixed N=5, 1 = round-robin N=5, 2 = round-robin N=1
  int nreq [3] = '{5, 5, 1};
  int mmode[3] = '{0, 1, 1};
  bit mv   [3];
  int midx [3];
  int mptr [3];

  always #5 clk = ~clk;

  priority_arbiter #(.NUM_REQ(5), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(v0), .grant_idx(gi0), .grant_onehot(oh0));

  priority_arbiter #(.NUM_REQ(5), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(v1), .grant_idx(gi1), .grant_onehot(oh1));

  priority_arbiter #(.NUM_REQ(1), .MODE(1)) u_one (
    .clk(clk), .rst_n(rst_n), .req(req[0:0]), .out_ready(out_ready),
    .out_valid(v2), .grant_idx(gi2), .grant_onehot(oh2));

  function automatic int req_of(int k);
    return (k == 2) ? int'(req[0]) : int'(req);
  endfunction

  // First requester at or after 'from', circularly.
  function automatic int pick(int r, int from, int n);
    for (int s = 0; s < n; s++) begin
      int c;
      c = (from + s) % n;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; midx[k] = 0; mptr[k] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      int r;
      r = req_of(k);
      if (!mv[k]) begin
        if (r != 0) begin
          mv[k]   = 1'b1;
          midx[k] = pick(r, (mmode[k] == 1) ? mptr[k] : 0, nreq[k]);
        end
      end else if (out_ready) begin
        if (mmode[k] == 1) mptr[k] = (midx[k] + 1) % nreq[k];
        if (r != 0) midx[k] = pick(r, (mmode[k] == 1) ? mptr[k] : 0, nreq[k]);
        else        mv[k]   = 1'b0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] ov, oi, oo;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin ov = 32'(v0); oi = 32'(gi0); oo = 32'(oh0); end
        1:       begin ov = 32'(v1); oi = 32'(gi1); oo = 32'(oh1); end
        default: begin ov = 32'(v2); oi = 32'(gi2); oo = 32'(oh2); end
      endcase
      check($sformatf("%s.u%0d.valid", tag, k), ov, 32'(mv[k]));
      check($sformatf("%s.u%0d.idx", tag, k), oi, 32'(midx[k]));
      check($sformatf("%s.u%0d.onehot", tag, k), oo,
            mv[k] ? (32'd1 << midx[k]) : 32'd0);
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, check the immediate drop, then release.
  task automatic pulse_reset(string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    step({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[5];
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    model_reset();
    #2;

    // Reset held with no requests for 10 cycles
    for (int c = 0; c < 10; c++) step("rst_idle");
    rst_n = 1'b1;
    step("idle_after_rst");

    // Fixed priority picks index 2 of 10100 every cycle
    req = 5'b10100; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step("fix_10100");
      check("fix_10100.const_idx", 32'(gi0), 32'd2);
    end

    // Round-robin 10101 from a fresh pointer: 0,2,4,0,2
    pulse_reset("rst_a");
    req = 5'b10101; out_ready = 1'b1;
    exp_seq = '{0, 2, 4, 0, 2};
    for (int c = 0; c < 5; c++) begin
      step("rr_10101");
      check("rr_10101.const_idx", 32'(gi1), 32'(exp_seq[c]));
    end

    // Grant 2 held under back-pressure while requests change, then 1
    pulse_reset("rst_b");
    req = 5'b00100; out_ready = 1'b0;
    step("rr_hold_first");
    for (int c = 0; c < 3; c++) begin
      req = (c == 0) ? 5'b00100 : 5'b00010;
      step("rr_hold");
      check("rr_hold.const_idx", 32'(gi1), 32'd2);
      check("rr_hold.const_oh", 32'(oh1), 32'b00100);
    end
    out_ready = 1'b1;
    step("rr_release");
    check("rr_release.const_idx", 32'(gi1), 32'd1);

    // Wrap from 4 back to 0
    pulse_reset("rst_c");
    req = 5'b10001; out_ready = 1'b1;
    exp_seq = '{0, 4, 0, 4, 0};
    for (int c = 0; c < 4; c++) begin
      step("rr_wrap");
      check("rr_wrap.const_idx", 32'(gi1), 32'(exp_seq[c]));
    end

    // Reset mid-grant discards grant 3; pointer restarts at 0
    pulse_reset("rst_d");
    req = 5'b11000; out_ready = 1'b0;
    step("rr_pre_reset");
    check("rr_pre_reset.const_idx", 32'(gi1), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rr_mid_reset.const_valid", 32'(v1), 32'd0);
    check_all("rr_mid_reset");
    step("rr_in_reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    step("rr_after_reset0");
    check("rr_after_reset0.const_idx", 32'(gi1), 32'd3);
    step("rr_after_reset1");
    check("rr_after_reset1.const_idx", 32'(gi1), 32'd4);

    // Handshake with no requests returns to idle
    req = '0;
    step("to_idle");
    step("stay_idle");

    // Randomized traffic, back-pressure and occasional resets
    for (int c = 0; c < 400; c++) begin
      req       = 5'($urandom);
      if ($urandom_range(0, 4) == 0) req = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_rst");
      else                            step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
